// File: rtl/signal_expansioner_pkg.sv
// Shared constants for the acquisition front-end trigger path.
// Holds the default width of the trigger-extension counter.
package signal_expansioner_pkg;

  localparam int DEFAULT_EXTEND_LEN_WIDTH = 5;

endpackage

// File: rtl/signal_expansioner.sv
// Pulse stretcher: registers SIG_IN and keeps SIG_OUT high for EXTEND_LEN
// extra cycles after SIG_IN falls, merging pulses whose gap fits in the tail.
module signal_expansioner
  import signal_expansioner_pkg::*;
#(
  parameter int MAX_EXTEND_LEN_WIDTH = DEFAULT_EXTEND_LEN_WIDTH
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic [MAX_EXTEND_LEN_WIDTH-1:0] EXTEND_LEN,
  input  logic                            SIG_IN,
  output logic                            SIG_OUT
);

  logic [MAX_EXTEND_LEN_WIDTH-1:0] cnt_q;
  logic [MAX_EXTEND_LEN_WIDTH-1:0] cnt_d;
  logic                            sig_out_q;
  logic                            sig_out_d;

  // Every high input cycle reloads the tail, so the last high cycle's
  // EXTEND_LEN wins; the counter then saturates at zero instead of wrapping.
  always_comb begin
    cnt_d     = cnt_q;
    sig_out_d = SIG_IN | (cnt_q != '0);
    if (SIG_IN) begin
      cnt_d = EXTEND_LEN;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q     <= '0;
      sig_out_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      sig_out_q <= sig_out_d;
    end
  end

  assign SIG_OUT = sig_out_q;

endmodule

// File: tb/tb_signal_expansioner.sv
// Directed bench for signal_expansioner: stretch, zero extension, merge,
// maximum tail, late EXTEND_LEN changes and reset in the middle of a tail.
module tb_signal_expansioner;

  logic       clock;
  logic       reset;
  logic [4:0] extendLen;
  logic       sigIn;
  logic       sigOut;

  int checkCount;
  int errorCount;

  signal_expansioner #(
    .MAX_EXTEND_LEN_WIDTH(5)
  ) dut (
    .CLK       (clock),
    .RESET     (reset),
    .EXTEND_LEN(extendLen),
    .SIG_IN    (sigIn),
    .SIG_OUT   (sigOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change just after an edge and are sampled on the next one;
  // returning #1 after that edge leaves the registered output settled.
  task automatic applyStimulus(input logic rst, input logic [4:0] len, input logic sin);
    reset     = rst;
    extendLen = len;
    sigIn     = sin;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: SIG_OUT=%b expected %b", tag, observed, expected);
    end
  endtask

  // Patterns are read left to right, one character per clock cycle.
  task automatic runPattern(input string tag, input logic [4:0] len,
                            input string inPat, input string expPat);
    for (int i = 0; i < inPat.len(); i++) begin
      applyStimulus(1'b0, len, inPat[i] == "1");
      checkOutput($sformatf("%s[%0d]", tag, i), sigOut, expPat[i] == "1");
    end
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    reset      = 1'b1;
    extendLen  = 5'd4;
    sigIn      = 1'b1;

    // Reset held with SIG_IN high never lets the strobe through.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 5'd4, 1'b1);
      checkOutput($sformatf("resetHold[%0d]", i), sigOut, 1'b0);
    end
    applyStimulus(1'b0, 5'd4, 1'b1);
    checkOutput("resetRelease", sigOut, 1'b1);
    applyStimulus(1'b1, 5'd0, 1'b0);
    checkOutput("resetClear", sigOut, 1'b0);
    applyStimulus(1'b0, 5'd0, 1'b0);
    checkOutput("idleAfterReset", sigOut, 1'b0);

    runPattern("basicStretch", 5'd4, "10000000", "11111000");
    runPattern("zeroExtend",   5'd0, "1111111000", "1111111000");
    runPattern("mergeGap3",    5'd3, "11000110000", "11111111110");
    runPattern("splitGap4",    5'd3, "110000110000", "111110111110");
    runPattern("singleCycleLen1", 5'd1, "1000100", "1100110");

    // Maximum tail, with EXTEND_LEN dropped to 2 while the tail runs.
    applyStimulus(1'b0, 5'd31, 1'b1);
    checkOutput("maxTail[0]", sigOut, 1'b1);
    for (int i = 1; i < 35; i++) begin
      applyStimulus(1'b0, (i >= 5) ? 5'd2 : 5'd31, 1'b0);
      checkOutput($sformatf("maxTail[%0d]", i), sigOut, (i < 32) ? 1'b1 : 1'b0);
    end

    // Only the EXTEND_LEN seen on the final high cycle sets the tail.
    applyStimulus(1'b0, 5'd5, 1'b1);
    checkOutput("lastLen[0]", sigOut, 1'b1);
    applyStimulus(1'b0, 5'd1, 1'b1);
    checkOutput("lastLen[1]", sigOut, 1'b1);
    applyStimulus(1'b0, 5'd5, 1'b0);
    checkOutput("lastLen[2]", sigOut, 1'b1);
    applyStimulus(1'b0, 5'd5, 1'b0);
    checkOutput("lastLen[3]", sigOut, 1'b0);

    // Reset three cycles into a 10-cycle tail leaves nothing behind.
    applyStimulus(1'b0, 5'd10, 1'b1);
    checkOutput("midTailStart", sigOut, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 5'd10, 1'b0);
      checkOutput($sformatf("midTailRun[%0d]", i), sigOut, 1'b1);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 5'd10, 1'b0);
      checkOutput($sformatf("midTailReset[%0d]", i), sigOut, 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 5'd10, 1'b0);
      checkOutput($sformatf("midTailAfter[%0d]", i), sigOut, 1'b0);
    end
    applyStimulus(1'b0, 5'd0, 1'b1);
    checkOutput("midTailRetrig", sigOut, 1'b1);
    applyStimulus(1'b0, 5'd0, 1'b0);
    checkOutput("midTailEnd", sigOut, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/signal_expansioner.md
# signal_expansioner

Pulse stretcher that holds a registered copy of an input strobe high for a programmable number of extra clock cycles after the input falls. In the acquisition front end it turns the per-sample trigger valid into a contiguous write-enable window. The window covers the trigger plus a trailing extension, so the downstream frame builder records a configurable number of samples beyond the last triggered one.

## Interface
- MAX_EXTEND_LEN_WIDTH, default 5: width of EXTEND_LEN and of the internal down-counter; max extension = 2^W-1 cycles.

- CLK  in  1  single clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset; one clock, synchronous active-high.
- EXTEND_LEN  in  MAX_EXTEND_LEN_WIDTH  number of cycles SIG_OUT stays high after SIG_IN deasserts (unsigned).
- SIG_IN  in  1  input strobe (level, any pulse width).
- SIG_OUT  out  1  stretched, registered strobe.

## Operation
- Internal state:
  - cnt: MAX_EXTEND_LEN_WIDTH bits, unsigned down-counter.
  - sig_out_q: 1-bit register driving SIG_OUT.
- Each rising CLK edge, RESET=1:
  - cnt <= 0, sig_out_q <= 0.
  - SIG_IN and EXTEND_LEN are ignored.
- Each rising CLK edge, RESET=0:
  - sig_out_q <= SIG_IN | (cnt != 0).
  - If SIG_IN=1: cnt <= EXTEND_LEN (reload).
  - Else if cnt != 0: cnt <= cnt-1.
  - Else: cnt holds 0.
- EXTEND_LEN is sampled on every cycle SIG_IN=1; the value on the last high cycle of SIG_IN governs the extension. Changing EXTEND_LEN while counting down has no effect on the current tail.
- Retrigger: SIG_IN rising during a tail reloads cnt. SIG_OUT stays continuously high with no gap.
- EXTEND_LEN=0: SIG_OUT is SIG_IN delayed by exactly one cycle.
- Decrement never wraps; cnt saturates at 0.
- No other state. No combinational path from any input to SIG_OUT.

## Timing
- Latency: SIG_IN rising at edge k (sampled high at k) gives SIG_OUT=1 after edge k.
- Pulse width: a SIG_IN high run of P cycles followed by low produces a SIG_OUT high run of exactly P+EXTEND_LEN cycles, starting one cycle after SIG_IN rises.
- Merging: two SIG_IN pulses separated by a gap of G low cycles merge into one SIG_OUT pulse iff G <= EXTEND_LEN.
- Reset values: SIG_OUT=0, cnt=0.
- Reset mid-tail: SIG_OUT is 0 after the first reset edge. After reset release, SIG_OUT rises only on a new SIG_IN=1; no residual tail.
- SIG_IN=1 on the reset-release cycle: sampled normally on the first edge with RESET=0.

## Structure
- Single flat module, two registers; no sub-modules and no FSM beyond the counter.
- No shared package required. MAX_EXTEND_LEN_WIDTH is a module parameter.
- If the project's common package defines a default trigger-extension width, bind the default to that constant.

## Test plan
- Reset: hold RESET=1 for 3 cycles with SIG_IN=1 -> SIG_OUT=0 throughout. First edge after release with SIG_IN=1 -> SIG_OUT=1.
- Basic stretch: EXTEND_LEN=4, SIG_IN high for 1 cycle at edge 10 -> SIG_OUT high after edges 10..14 (5 cycles), low thereafter.
- Long pulse, zero extension: EXTEND_LEN=0, SIG_IN high for 7 cycles -> SIG_OUT is an identical 7-cycle pulse delayed by 1 cycle.
- Retrigger/merge: EXTEND_LEN=3; 2-cycle SIG_IN pulses with gap 3 -> one merged SIG_OUT pulse. Same pulses with gap 4 -> two SIG_OUT pulses separated by exactly 1 low cycle.
- Max width: W=5, EXTEND_LEN=31, 1-cycle pulse -> SIG_OUT high 32 cycles. EXTEND_LEN changed to 2 mid-tail -> tail still 31.
- Reset mid-tail: EXTEND_LEN=10, RESET asserted 3 cycles after SIG_IN falls -> SIG_OUT=0 from the next edge and stays 0 after release until SIG_IN=1.
